// File: rtl/morse_char_assembler_pkg.sv
// Shared types and constants for the Morse character assembler.
package morse_char_assembler_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_LETTER} state_e;

  localparam logic [7:0]  ASC_SPACE    = 8'h20;
  localparam logic [7:0]  ASC_QMARK    = 8'h3F;
  localparam int unsigned LG_UNITS_DEF = 3;
  localparam int unsigned WG_UNITS_DEF = 7;
  localparam int unsigned LUT_SYM      = 5;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse lookup: (len, pattern) -> ASCII. First symbol sits at bit len-1, dash = 1.
module morse_lut
  import morse_char_assembler_pkg::*;
(
  input  logic [2:0]         len_i,
  input  logic [LUT_SYM-1:0] pattern_i,
  output logic               hit_o,
  output logic [7:0]         ascii_o
);

  logic [LUT_SYM-1:0] mask;
  logic [LUT_SYM-1:0] pat;

  always_comb begin
    mask    = (LUT_SYM'(1) << len_i) - LUT_SYM'(1);
    pat     = pattern_i & mask;
    hit_o   = 1'b1;
    ascii_o = ASC_QMARK;
    case ({len_i, pat})
      {3'd1, 5'b00000}: ascii_o = "E";
      {3'd1, 5'b00001}: ascii_o = "T";
      {3'd2, 5'b00000}: ascii_o = "I";
      {3'd2, 5'b00001}: ascii_o = "A";
      {3'd2, 5'b00010}: ascii_o = "N";
      {3'd2, 5'b00011}: ascii_o = "M";
      {3'd3, 5'b00000}: ascii_o = "S";
      {3'd3, 5'b00001}: ascii_o = "U";
      {3'd3, 5'b00010}: ascii_o = "R";
      {3'd3, 5'b00011}: ascii_o = "W";
      {3'd3, 5'b00100}: ascii_o = "D";
      {3'd3, 5'b00101}: ascii_o = "K";
      {3'd3, 5'b00110}: ascii_o = "G";
      {3'd3, 5'b00111}: ascii_o = "O";
      {3'd4, 5'b00000}: ascii_o = "H";
      {3'd4, 5'b00001}: ascii_o = "V";
      {3'd4, 5'b00010}: ascii_o = "F";
      {3'd4, 5'b00100}: ascii_o = "L";
      {3'd4, 5'b00110}: ascii_o = "P";
      {3'd4, 5'b00111}: ascii_o = "J";
      {3'd4, 5'b01000}: ascii_o = "B";
      {3'd4, 5'b01001}: ascii_o = "X";
      {3'd4, 5'b01010}: ascii_o = "C";
      {3'd4, 5'b01011}: ascii_o = "Y";
      {3'd4, 5'b01100}: ascii_o = "Z";
      {3'd4, 5'b01101}: ascii_o = "Q";
      {3'd5, 5'b11111}: ascii_o = "0";
      {3'd5, 5'b01111}: ascii_o = "1";
      {3'd5, 5'b00111}: ascii_o = "2";
      {3'd5, 5'b00011}: ascii_o = "3";
      {3'd5, 5'b00001}: ascii_o = "4";
      {3'd5, 5'b00000}: ascii_o = "5";
      {3'd5, 5'b10000}: ascii_o = "6";
      {3'd5, 5'b11000}: ascii_o = "7";
      {3'd5, 5'b11100}: ascii_o = "8";
      {3'd5, 5'b11110}: ascii_o = "9";
      default: begin
        hit_o   = 1'b0;
        ascii_o = ASC_QMARK;
      end
    endcase
  end

endmodule

// File: rtl/morse_char_assembler.sv
// Buffers dot/dash pulses, times the idle gap on b and emits a character on a letter gap
// or a space on a word gap.
module morse_char_assembler
  import morse_char_assembler_pkg::*;
#(
  parameter int unsigned TIME_UNIT = 9_999_999,
  parameter int unsigned LG_UNITS  = LG_UNITS_DEF,
  parameter int unsigned WG_UNITS  = WG_UNITS_DEF,
  parameter int unsigned MAX_SYM   = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       b,
  input  logic       dot,
  input  logic       dash,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       lg,
  output logic       wg,
  output logic       err
);

  localparam int unsigned CntW  = $clog2(TIME_UNIT + 1);
  localparam int unsigned UnitW = $clog2(WG_UNITS + 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cyc_q, cyc_d;
  logic [UnitW-1:0]   units_q, units_d;
  logic [MAX_SYM-1:0] pattern_q, pattern_d;
  logic [2:0]         len_q, len_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         char_q, char_d;
  logic               cv_q, cv_d, lg_q, lg_d, wg_q, wg_d, err_q, err_d;

  logic clr, sym, tick, lg_hit, wg_hit, emit_lg, emit_wg;
  logic lut_hit;
  logic [7:0] lut_ascii;

  // Both pulses together count as activity (clearing the gap) but carry no symbol.
  assign clr     = b | dot | dash;
  assign sym     = dot ^ dash;
  assign tick    = !clr && (cyc_q == CntW'(TIME_UNIT));
  assign lg_hit  = tick && (units_q == UnitW'(LG_UNITS - 1));
  assign wg_hit  = tick && (units_q == UnitW'(WG_UNITS - 1));
  assign emit_lg = (state_q == ST_COLLECT) && lg_hit;
  assign emit_wg = (state_q == ST_LETTER) && wg_hit;

  morse_lut u_lut (
    .len_i     (len_q),
    .pattern_i (LUT_SYM'(pattern_q)),
    .hit_o     (lut_hit),
    .ascii_o   (lut_ascii)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (sym) state_d = ST_COLLECT;
      ST_COLLECT: if (lg_hit) state_d = ST_LETTER;
      ST_LETTER: begin
        if (sym)         state_d = ST_COLLECT;
        else if (wg_hit) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cyc_d     = (clr || tick) ? '0 : cyc_q + 1'b1;
    units_d   = units_q;
    if (clr) units_d = '0;
    else if (tick && (units_q != UnitW'(WG_UNITS))) units_d = units_q + 1'b1;
    pattern_d = pattern_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    if (emit_lg) begin
      pattern_d = '0;
      len_d     = '0;
      ovf_d     = 1'b0;
    end else if (sym) begin
      if (len_q == 3'(MAX_SYM)) begin
        ovf_d = 1'b1;
      end else begin
        pattern_d = {pattern_q[MAX_SYM-2:0], dash};
        len_d     = len_q + 3'd1;
      end
    end
  end

  always_comb begin
    cv_d   = emit_lg | emit_wg;
    lg_d   = emit_lg;
    wg_d   = emit_wg;
    err_d  = emit_lg && (ovf_q || !lut_hit);
    char_d = char_q;
    if (emit_lg)      char_d = err_d ? ASC_QMARK : lut_ascii;
    else if (emit_wg) char_d = ASC_SPACE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q     <= '0;
      units_q   <= '0;
      pattern_q <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      char_q    <= 8'h00;
      cv_q      <= 1'b0;
      lg_q      <= 1'b0;
      wg_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cyc_q     <= cyc_d;
      units_q   <= units_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      char_q    <= char_d;
      cv_q      <= cv_d;
      lg_q      <= lg_d;
      wg_q      <= wg_d;
      err_q     <= err_d;
    end
  end

  assign char_out   = char_q;
  assign char_valid = cv_q;
  assign lg         = lg_q;
  assign wg         = wg_q;
  assign err        = err_q;

endmodule

// File: tb/tb_morse_char_assembler.sv
// Scoreboard bench for morse_char_assembler with one unit = 4 cycles.
module tb_morse_char_assembler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       b = 1'b0;
  logic       dot = 1'b0;
  logic       dash = 1'b0;
  logic [7:0] char_out;
  logic       char_valid, lg, wg, err;

  always #5 clk = ~clk;

  morse_char_assembler #(
    .TIME_UNIT (3),
    .LG_UNITS  (3),
    .WG_UNITS  (7),
    .MAX_SYM   (5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .b          (b),
    .dot        (dot),
    .dash       (dash),
    .char_out   (char_out),
    .char_valid (char_valid),
    .lg         (lg),
    .wg         (wg),
    .err        (err)
  );

  typedef struct {
    logic [7:0] ch;
    logic       lg;
    logic       wg;
    logic       err;
    int         at;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc_n = 0;
  int   last_clr = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Monitor: every strobe must match the head of the scoreboard, in content and cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n && (char_valid || lg || wg || err)) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe cyc=%0d got cv=%b ch=%h lg=%b wg=%b err=%b, want none",
                 cyc_n, char_valid, char_out, lg, wg, err);
      end else begin
        e = q.pop_front();
        if ({char_valid, char_out, lg, wg, err} !== {1'b1, e.ch, e.lg, e.wg, e.err}) begin
          n_fail++;
          $display("FAIL strobe_content cyc=%0d got cv=%b ch=%h lg=%b wg=%b err=%b, want cv=1 ch=%h lg=%b wg=%b err=%b",
                   cyc_n, char_valid, char_out, lg, wg, err, e.ch, e.lg, e.wg, e.err);
        end
        n_tests++;
        if (cyc_n != e.at) begin
          n_fail++;
          $display("FAIL strobe_timing ch=%h got cyc=%0d, want cyc=%0d", e.ch, cyc_n, e.at);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] ch, input logic l, input logic w, input logic e,
                      input int at);
    exp_t x;
    x.ch = ch; x.lg = l; x.wg = w; x.err = e; x.at = at;
    q.push_back(x);
  endtask

  // One-cycle symbol pulse followed by one idle cycle; records the clearing edge.
  task automatic pulse(input logic d, input logic h);
    dot = d;
    dash = h;
    last_clr = cyc_n + 1;
    step(1);
    dot = 1'b0;
    dash = 1'b0;
    step(1);
  endtask

  // Letter at 3 units after the last activity, space at 7 units.
  task automatic expect_letter(input logic [7:0] ch, input logic e);
    push(ch, 1'b1, 1'b0, e, last_clr + 12);
    push(8'h20, 1'b0, 1'b1, 1'b0, last_clr + 28);
  endtask

  task automatic letter(input string syms, input logic [7:0] ch, input logic e);
    for (int i = 0; i < syms.len(); i++) pulse(syms[i] == 8'h2E, syms[i] == 8'h2D);
    expect_letter(ch, e);
    step(36);
  endtask

  initial begin
    step(3);
    chk("reset_char_valid", {31'd0, char_valid}, 32'd0);
    chk("reset_char_out", {24'd0, char_out}, 32'd0);
    chk("reset_lg", {31'd0, lg}, 32'd0);
    chk("reset_wg", {31'd0, wg}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    reset_n = 1'b1;
    step(2);

    letter(".-", 8'h41, 1'b0);
    letter(".", 8'h45, 1'b0);
    step(40);
    letter("-----", 8'h30, 1'b0);
    letter("------", 8'h3F, 1'b1);
    letter("..--", 8'h3F, 1'b1);

    // Simultaneous dot+dash: ignored for the buffer but restarts the gap.
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    expect_letter(8'h45, 1'b0);
    step(36);

    // Key pressed mid-gap restarts timing from the release.
    pulse(1'b1, 1'b0);
    step(7);
    b = 1'b1;
    step(2);
    b = 1'b0;
    last_clr = cyc_n;
    expect_letter(8'h45, 1'b0);
    step(36);

    // A symbol after an interrupted gap extends the same letter.
    pulse(1'b1, 1'b0);
    step(4);
    b = 1'b1;
    step(1);
    b = 1'b0;
    pulse(1'b0, 1'b1);
    expect_letter(8'h41, 1'b0);
    step(36);

    // Reset mid-gap discards the buffer silently.
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    step(6);
    reset_n = 1'b0;
    step(1);
    chk("midreset_char_valid", {31'd0, char_valid}, 32'd0);
    chk("midreset_char_out", {24'd0, char_out}, 32'd0);
    step(2);
    reset_n = 1'b1;
    step(30);
    letter(".", 8'h45, 1'b0);

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
